// File: rtl/return_addr_stack_if.sv
// Frontend <-> return-address-stack connection: call/return controls in, prediction out.
// The frontend drives through the master modport; the stack itself uses slave.
interface return_addr_stack_if #(
    parameter int DEPTH = 4,
    parameter int VLEN  = 64
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             flush_i;
    logic             push_i;
    logic             pop_i;
    logic [VLEN-1:0]  pc_i;
    logic             is_rvc_i;
    logic             checkpoint_i;
    logic             restore_i;
    logic             ras_valid_o;
    logic [VLEN-1:0]  ras_addr_o;
    logic [CNT_W-1:0] count_o;
    logic             overflow_o;

    modport master (
        output flush_i, push_i, pop_i, pc_i, is_rvc_i, checkpoint_i, restore_i,
        input  ras_valid_o, ras_addr_o, count_o, overflow_o
    );

    modport slave (
        input  flush_i, push_i, pop_i, pc_i, is_rvc_i, checkpoint_i, restore_i,
        output ras_valid_o, ras_addr_o, count_o, overflow_o
    );
endinterface

// File: rtl/return_addr_stack.sv
// Circular return-address stack that pushes link addresses on calls and predicts on returns.
// A single checkpoint of tos/count/top lets the frontend undo speculative updates.
module return_addr_stack #(
    parameter int DEPTH = 4,
    parameter int VLEN  = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    return_addr_stack_if.slave  ras
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [VLEN-1:0]  entries [DEPTH];
    logic [PTR_W-1:0] tos;
    logic [CNT_W-1:0] count;
    logic             overflow_q;
    logic [PTR_W-1:0] snap_tos;
    logic [CNT_W-1:0] snap_count;
    logic [VLEN-1:0]  snap_top;

    logic [VLEN-1:0]  link_addr;
    logic [PTR_W-1:0] tos_inc;
    logic [PTR_W-1:0] next_tos;
    logic [CNT_W-1:0] next_count;
    logic [VLEN-1:0]  next_top;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [VLEN-1:0]  wr_data;
    logic             overflow_next;
    logic             snap_en;

    always_comb begin
        link_addr     = ras.pc_i + (ras.is_rvc_i ? VLEN'(2) : VLEN'(4));
        tos_inc       = tos + PTR_W'(1);
        next_tos      = tos;
        next_count    = count;
        wr_en         = 1'b0;
        wr_idx        = tos;
        wr_data       = link_addr;
        overflow_next = 1'b0;
        snap_en       = 1'b0;

        if (ras.flush_i) begin
            next_tos   = '0;
            next_count = '0;
        end else if (ras.restore_i) begin
            // The top slot may have been clobbered by a speculative push, so rewrite it
            next_tos   = snap_tos;
            next_count = snap_count;
            wr_en      = 1'b1;
            wr_idx     = snap_tos;
            wr_data    = snap_top;
        end else begin
            if (ras.push_i && (!ras.pop_i || count == '0)) begin
                next_tos = tos_inc;
                wr_en    = 1'b1;
                wr_idx   = tos_inc;
                if (count == CNT_W'(DEPTH)) begin
                    overflow_next = 1'b1;
                end else begin
                    next_count = count + CNT_W'(1);
                end
            end else if (ras.push_i && ras.pop_i) begin
                wr_en  = 1'b1;
                wr_idx = tos;
            end else if (ras.pop_i && count != '0) begin
                next_tos   = tos - PTR_W'(1);
                next_count = count - CNT_W'(1);
            end
            snap_en = ras.checkpoint_i;
        end

        // Snapshot sees the post-update top, including a write landing this cycle
        next_top = (wr_en && wr_idx == next_tos) ? wr_data : entries[next_tos];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tos        <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
            snap_tos   <= '0;
            snap_count <= '0;
            snap_top   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            tos        <= next_tos;
            count      <= next_count;
            overflow_q <= overflow_next;
            if (wr_en) begin
                entries[wr_idx] <= wr_data;
            end
            if (ras.flush_i) begin
                snap_tos   <= '0;
                snap_count <= '0;
            end else if (snap_en) begin
                snap_tos   <= next_tos;
                snap_count <= next_count;
                snap_top   <= next_top;
            end
        end
    end

    assign ras.ras_addr_o  = entries[tos];
    assign ras.ras_valid_o = (count != '0);
    assign ras.count_o     = count;
    assign ras.overflow_o  = overflow_q;
endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack: directed scenarios plus random traffic
// compared against a behavioural stack model.
module tb_return_addr_stack;
    localparam int DEPTH = 4;
    localparam int VLEN  = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    return_addr_stack_if #(.DEPTH(DEPTH), .VLEN(VLEN)) bus ();

    return_addr_stack #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .ras   (bus)
    );

    // Reference model: stack state as the behaviour rules describe it
    logic [VLEN-1:0] m_ent [DEPTH];
    int              m_tos, m_cnt, s_tos, s_cnt;
    logic [VLEN-1:0] s_top;
    bit              m_ovf;

    task automatic model_step(input bit r, f, pu, po, input logic [VLEN-1:0] pc,
                              input bit rvc, ck, rs);
        logic [VLEN-1:0] link;
        link = pc + (rvc ? 64'd2 : 64'd4);
        m_ovf = 0;
        if (r) begin
            m_tos = 0; m_cnt = 0; s_tos = 0; s_cnt = 0; s_top = '0;
            for (int i = 0; i < DEPTH; i++) m_ent[i] = '0;
        end else if (f) begin
            m_tos = 0; m_cnt = 0; s_tos = 0; s_cnt = 0;
        end else if (rs) begin
            m_tos = s_tos; m_cnt = s_cnt; m_ent[m_tos] = s_top;
        end else begin
            if (pu && po && m_cnt > 0) begin
                m_ent[m_tos] = link;
            end else if (pu) begin
                if (m_cnt == DEPTH) m_ovf = 1; else m_cnt++;
                m_tos = (m_tos + 1) % DEPTH;
                m_ent[m_tos] = link;
            end else if (po && m_cnt > 0) begin
                m_tos = (m_tos + DEPTH - 1) % DEPTH;
                m_cnt--;
            end
            if (ck) begin
                s_tos = m_tos; s_cnt = m_cnt; s_top = m_ent[m_tos];
            end
        end
    endtask

    task automatic drive(input bit r, f, pu, po, input logic [VLEN-1:0] pc,
                         input bit rvc, ck, rs);
        rst = r; bus.flush_i = f; bus.push_i = pu; bus.pop_i = po; bus.pc_i = pc;
        bus.is_rvc_i = rvc; bus.checkpoint_i = ck; bus.restore_i = rs;
        model_step(r, f, pu, po, pc, rvc, ck, rs);
        @(posedge clk);
        #1;
        rst = 0; bus.flush_i = 0; bus.push_i = 0; bus.pop_i = 0; bus.pc_i = '0;
        bus.is_rvc_i = 0; bus.checkpoint_i = 0; bus.restore_i = 0;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        total++; if (bus.count_o !== 3'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count_o); end
        total++; if (bus.ras_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0b expected 0", bus.ras_valid_o); end
        total++; if (bus.ras_addr_o !== 64'h0) begin bad++; $display("[TB] FAIL reset_addr: got %0h expected 0", bus.ras_addr_o); end
        total++; if (bus.overflow_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %0b expected 0", bus.overflow_o); end
    endtask

    task automatic test_push_pop();
        logic [VLEN-1:0] exp_pop [3];
        exp_pop = '{64'h3004, 64'h2002, 64'h1004};
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 64'h1000, 0, 0, 0);
        drive(0, 0, 1, 0, 64'h2000, 1, 0, 0);
        drive(0, 0, 1, 0, 64'h3000, 0, 0, 0);
        total++; if (bus.count_o !== 3'd3) begin bad++; $display("[TB] FAIL push3_count: got %0d expected 3", bus.count_o); end
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.ras_addr_o !== exp_pop[i]) begin bad++; $display("[TB] FAIL pop_addr[%0d]: got %0h expected %0h", i, bus.ras_addr_o, exp_pop[i]); end
            drive(0, 0, 0, 1, 0, 0, 0, 0);
        end
        total++; if (bus.ras_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL empty_valid: got %0b expected 0", bus.ras_valid_o); end
    endtask

    task automatic test_overflow();
        logic [VLEN-1:0] exp_pop [4];
        exp_pop = '{64'h604, 64'h504, 64'h404, 64'h304};
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            drive(0, 0, 1, 0, 64'(i * 256), 0, 0, 0);
            total++; if (bus.overflow_o !== (i >= 5)) begin bad++; $display("[TB] FAIL ovf_after_push%0d: got %0b expected %0b", i, bus.overflow_o, (i >= 5)); end
        end
        total++; if (bus.count_o !== 3'd4) begin bad++; $display("[TB] FAIL full_count: got %0d expected 4", bus.count_o); end
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.ras_addr_o !== exp_pop[i]) begin bad++; $display("[TB] FAIL wrap_pop[%0d]: got %0h expected %0h", i, bus.ras_addr_o, exp_pop[i]); end
            drive(0, 0, 0, 1, 0, 0, 0, 0);
            if (i == 0) begin
                total++; if (bus.overflow_o !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clears: got %0b expected 0", bus.overflow_o); end
            end
        end
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        total++; if (bus.count_o !== 3'd0) begin bad++; $display("[TB] FAIL underflow_count: got %0d expected 0", bus.count_o); end
        total++; if (bus.ras_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL underflow_valid: got %0b expected 0", bus.ras_valid_o); end
    endtask

    task automatic test_push_pop_same();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 64'h1000, 0, 0, 0);
        drive(0, 0, 1, 1, 64'h8000, 0, 0, 0);
        total++; if (bus.count_o !== 3'd1) begin bad++; $display("[TB] FAIL swap_count: got %0d expected 1", bus.count_o); end
        total++; if (bus.ras_addr_o !== 64'h8004) begin bad++; $display("[TB] FAIL swap_addr: got %0h expected 8004", bus.ras_addr_o); end
        drive(0, 0, 1, 1, 64'h40, 1, 0, 0);
        total++; if (bus.ras_addr_o !== 64'h42) begin bad++; $display("[TB] FAIL swap_rvc_addr: got %0h expected 42", bus.ras_addr_o); end
    endtask

    task automatic test_checkpoint_restore();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 64'hA000, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 64'hB000, 0, 0, 0);
        total++; if (bus.ras_addr_o !== 64'hB004) begin bad++; $display("[TB] FAIL spec_push_addr: got %0h expected b004", bus.ras_addr_o); end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        total++; if (bus.count_o !== 3'd1) begin bad++; $display("[TB] FAIL restore_count: got %0d expected 1", bus.count_o); end
        total++; if (bus.ras_addr_o !== 64'hA004) begin bad++; $display("[TB] FAIL restore_addr: got %0h expected a004", bus.ras_addr_o); end
    endtask

    task automatic test_priority();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 64'h100, 0, 0, 0);
        drive(0, 0, 1, 0, 64'h200, 0, 1, 0);
        drive(0, 0, 1, 0, 64'h300, 0, 0, 0);
        drive(0, 0, 1, 0, 64'h900, 0, 1, 1);
        total++; if (bus.count_o !== 3'd2) begin bad++; $display("[TB] FAIL prio_restore_count: got %0d expected 2", bus.count_o); end
        total++; if (bus.ras_addr_o !== 64'h204) begin bad++; $display("[TB] FAIL prio_restore_addr: got %0h expected 204", bus.ras_addr_o); end
        drive(0, 0, 1, 0, 64'h400, 0, 0, 0);
        drive(0, 0, 1, 0, 64'h500, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        total++; if (bus.count_o !== 3'd2) begin bad++; $display("[TB] FAIL prio_snap_kept: got %0d expected 2", bus.count_o); end
        drive(0, 1, 1, 0, 64'h700, 0, 1, 0);
        total++; if (bus.count_o !== 3'd0) begin bad++; $display("[TB] FAIL flush_count: got %0d expected 0", bus.count_o); end
        total++; if (bus.ras_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid: got %0b expected 0", bus.ras_valid_o); end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        total++; if (bus.count_o !== 3'd0) begin bad++; $display("[TB] FAIL flush_restore_count: got %0d expected 0", bus.count_o); end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 64'h10, 0, 1, 0);
        drive(0, 0, 1, 0, 64'h20, 0, 1, 0);
        drive(1, 0, 1, 0, 64'h30, 0, 0, 0);
        total++; if (bus.count_o !== 3'd0) begin bad++; $display("[TB] FAIL midrst_count: got %0d expected 0", bus.count_o); end
        total++; if (bus.ras_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid: got %0b expected 0", bus.ras_valid_o); end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        total++; if (bus.count_o !== 3'd0) begin bad++; $display("[TB] FAIL midrst_restore: got %0d expected 0", bus.count_o); end
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 64'(i * 16), 0, 0, 0);
        drive(1, 0, 1, 0, 64'h50, 0, 0, 0);
        total++; if (bus.overflow_o !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ovf: got %0b expected 0", bus.overflow_o); end
    endtask

    task automatic test_random();
        bit r, f, pu, po, rvc, ck, rs;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 99) < 2);
            f   = ($urandom_range(0, 99) < 3);
            rs  = ($urandom_range(0, 99) < 8);
            ck  = ($urandom_range(0, 99) < 15);
            pu  = ($urandom_range(0, 99) < 45);
            po  = ($urandom_range(0, 99) < 40);
            rvc = $urandom_range(0, 1) == 1;
            drive(r, f, pu, po, {$urandom, $urandom}, rvc, ck, rs);
            total++; if (bus.count_o !== 3'(m_cnt)) begin bad++; $display("[TB] FAIL rnd_count@%0d: got %0d expected %0d", n, bus.count_o, m_cnt); end
            total++; if (bus.ras_valid_o !== (m_cnt != 0)) begin bad++; $display("[TB] FAIL rnd_valid@%0d: got %0b expected %0b", n, bus.ras_valid_o, (m_cnt != 0)); end
            total++; if (bus.overflow_o !== m_ovf) begin bad++; $display("[TB] FAIL rnd_ovf@%0d: got %0b expected %0b", n, bus.overflow_o, m_ovf); end
            if (m_cnt > 0) begin
                total++; if (bus.ras_addr_o !== m_ent[m_tos]) begin bad++; $display("[TB] FAIL rnd_addr@%0d: got %0h expected %0h", n, bus.ras_addr_o, m_ent[m_tos]); end
            end
        end
    endtask

    initial begin
        bus.flush_i = 0; bus.push_i = 0; bus.pop_i = 0; bus.pc_i = '0;
        bus.is_rvc_i = 0; bus.checkpoint_i = 0; bus.restore_i = 0;
        #2;
        test_reset();
        test_push_pop();
        test_overflow();
        test_push_pop_same();
        test_checkpoint_restore();
        test_priority();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
